// File: rtl/alu_sequencer.sv
// Purpose: issuing sequencer for a 32-bit combinational ALU, with multi-cycle MULT (low 32 bits) done by shift-and-add on the ALU ADD op.
// Latency: illegal 0, single op 1, MULT 32 edges from the accept edge to rsp_valid_o.
// Backpressure: one request in flight; req_ready_o only in IDLE; the response is held in RESP until rsp_ready_i.
module alu_sequencer #(
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  aluop_i,
    input  logic [5:0]  funct_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] alu_src1_o,
    output logic [31:0] alu_src2_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result_i,
    input  logic        alu_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic        rsp_zero_o,
    output logic        rsp_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, MUL, RESP} state_t;

    localparam logic [3:0] C_ADD = 4'd2;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;        // operand 1, or the accumulator during MUL
    logic [31:0] r_q;        // operand 2, or the multiplier during MUL
    logic [31:0] r_m;        // shifted multiplicand
    logic [3:0]  r_ctrl;
    logic [4:0]  r_cnt;
    logic [31:0] r_hold1;
    logic [31:0] r_hold2;
    logic [3:0]  r_holdc;
    logic [31:0] r_res;
    logic        r_zero;
    logic        r_err;

    logic        w_legal;
    logic        w_is_mul;
    logic [3:0]  w_dec_ctrl;
    logic        w_accept;
    logic        w_drive;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic [3:0]  w_ctrl;

    // Decode ALUOp/funct into the ALU control code and the legal/mult flags.
    always_comb begin
        w_legal    = 1'b1;
        w_is_mul   = 1'b0;
        w_dec_ctrl = 4'd0;
        case (aluop_i)
            3'b000: w_dec_ctrl = 4'd2;
            3'b001: w_dec_ctrl = 4'd6;
            3'b011: w_dec_ctrl = 4'd7;
            3'b100: w_dec_ctrl = 4'd1;
            3'b101: w_dec_ctrl = 4'd9;
            3'b010: begin
                case (funct_i)
                    6'd32:   w_dec_ctrl = 4'd2;
                    6'd34:   w_dec_ctrl = 4'd6;
                    6'd36:   w_dec_ctrl = 4'd0;
                    6'd37:   w_dec_ctrl = 4'd1;
                    6'd39:   w_dec_ctrl = 4'd12;
                    6'd42:   w_dec_ctrl = 4'd7;
                    6'd3:    w_dec_ctrl = 4'd8;
                    6'd24: begin
                        w_dec_ctrl = C_ADD;
                        w_is_mul   = MUL_EN;
                        w_legal    = MUL_EN;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign req_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == RESP);
    assign w_accept    = req_valid_i & req_ready_o;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!w_legal)     w_next = RESP;
                    else if (w_is_mul) w_next = MUL;
                    else              w_next = ISSUE;
                end
            end
            ISSUE:   w_next = RESP;
            MUL:     if (r_cnt == 5'd31) w_next = RESP;
            RESP:    if (rsp_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ALU drive comes only from latched state; outside ISSUE/MUL the last driven value is replayed.
    assign w_drive    = (r_state == ISSUE) || (r_state == MUL);
    assign w_src1     = r_a;
    assign w_src2     = (r_state == MUL) ? (r_q[0] ? r_m : 32'd0) : r_q;
    assign w_ctrl     = (r_state == MUL) ? C_ADD : r_ctrl;
    assign alu_src1_o = w_drive ? w_src1 : r_hold1;
    assign alu_src2_o = w_drive ? w_src2 : r_hold2;
    assign alu_ctrl_o = w_drive ? w_ctrl : r_holdc;

    // Remember the last values driven to the ALU.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold1 <= 32'd0;
            r_hold2 <= 32'd0;
            r_holdc <= 4'd0;
        end else if (w_drive) begin
            r_hold1 <= w_src1;
            r_hold2 <= w_src2;
            r_holdc <= w_ctrl;
        end
    end

    // Operand latching, shift-and-add iteration and response capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a    <= 32'd0;
            r_q    <= 32'd0;
            r_m    <= 32'd0;
            r_ctrl <= 4'd0;
            r_cnt  <= 5'd0;
            r_res  <= 32'd0;
            r_zero <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ctrl <= w_dec_ctrl;
                        r_cnt  <= 5'd0;
                        r_q    <= src2_i;
                        r_a    <= w_is_mul ? 32'd0 : src1_i;
                        r_m    <= w_is_mul ? src1_i : 32'd0;
                        if (!w_legal) begin
                            r_res  <= 32'd0;
                            r_zero <= 1'b0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_res  <= alu_result_i;
                    r_zero <= alu_zero_i;
                    r_err  <= 1'b0;
                end
                MUL: begin
                    r_a   <= alu_result_i;
                    r_m   <= {r_m[30:0], 1'b0};
                    r_q   <= {1'b0, r_q[31:1]};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_res  <= alu_result_i;
                        r_zero <= (alu_result_i == 32'd0);
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_result_o = r_res;
    assign rsp_zero_o   = r_zero;
    assign rsp_err_o    = r_err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose: self-checking bench for alu_sequencer with a behavioural ALU attached to its ALU ports.
// Latency: n/a (bench).
// Backpressure: exercises held responses and ignored requests while not ready.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o;
    logic [2:0]  aluop_i;
    logic [5:0]  funct_i;
    logic [31:0] src1_i, src2_i;
    logic [31:0] alu_src1_o, alu_src2_o, alu_result_i;
    logic [3:0]  alu_ctrl_o;
    logic        alu_zero_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_zero_o, rsp_err_o;
    logic [31:0] rsp_result_o;

    // Second instance with MULT disabled
    logic        v0_req_valid, v0_req_ready, v0_rsp_valid, v0_rsp_ready, v0_rsp_zero, v0_rsp_err;
    logic [31:0] v0_src1, v0_src2, v0_result, v0_rsp_result;
    logic [3:0]  v0_ctrl;
    logic        v0_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Behavioural ALU seen by the sequencer.
    function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd8:    return b >> a[4:0];
            4'd9:    return {b[15:0], 16'h0000};
            4'd12:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result_i = alu_fn(alu_ctrl_o, alu_src1_o, alu_src2_o);
    assign alu_zero_i   = (alu_result_i == 32'd0);
    assign v0_result    = alu_fn(v0_ctrl, v0_src1, v0_src2);
    assign v0_zero      = (v0_result == 32'd0);

    alu_sequencer #(.MUL_EN(1'b1)) u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .aluop_i(aluop_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
        .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_zero_o(rsp_zero_o), .rsp_err_o(rsp_err_o)
    );

    alu_sequencer #(.MUL_EN(1'b0)) u_dut_nomul (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(v0_req_valid), .req_ready_o(v0_req_ready),
        .aluop_i(aluop_i), .funct_i(funct_i), .src1_i(src1_i), .src2_i(src2_i),
        .alu_src1_o(v0_src1), .alu_src2_o(v0_src2), .alu_ctrl_o(v0_ctrl),
        .alu_result_i(v0_result), .alu_zero_i(v0_zero),
        .rsp_valid_o(v0_rsp_valid), .rsp_ready_i(v0_rsp_ready),
        .rsp_result_o(v0_rsp_result), .rsp_zero_o(v0_rsp_zero), .rsp_err_o(v0_rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: decode rules plus plain arithmetic; mult is just a*b mod 2^32.
    task automatic model(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic e, output int lat, output logic [3:0] c);
        logic mul;
        mul = 1'b0; e = 1'b0; c = 4'd0;
        case (op)
            3'd0: c = 4'd2;
            3'd1: c = 4'd6;
            3'd3: c = 4'd7;
            3'd4: c = 4'd1;
            3'd5: c = 4'd9;
            3'd2: case (fn)
                6'd32: c = 4'd2;  6'd34: c = 4'd6;  6'd36: c = 4'd0;  6'd37: c = 4'd1;
                6'd39: c = 4'd12; 6'd42: c = 4'd7;  6'd3:  c = 4'd8;
                6'd24: begin mul = 1'b1; c = 4'd2; end
                default: e = 1'b1;
            endcase
            default: e = 1'b1;
        endcase
        if (e) begin
            r = 32'd0; lat = 0;
        end else if (mul) begin
            r = a * b; lat = 32;
        end else begin
            r = alu_fn(c, a, b); lat = 1;
        end
        z = !e && (r == 32'd0);
    endtask

    // Issue one request, wait for its response, then consume it.
    task automatic send(input logic [2:0] op, input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic z, output logic e, output int lat,
                        output logic [3:0] ctl, output logic [3:0] pre_ctl);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) chk("req_ready_timeout", 32'd0, 32'd1);
        pre_ctl = alu_ctrl_o;
        aluop_i = op; funct_i = fn; src1_i = a; src2_i = b;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        // Scramble request inputs: results must come from latched operands only.
        aluop_i = 3'($urandom); funct_i = 6'($urandom); src1_i = $urandom; src2_i = $urandom;
        ctl = alu_ctrl_o;
        lat = 0;
        while (!rsp_valid_o && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = rsp_result_o; z = rsp_zero_o; e = rsp_err_o;
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
        int          lat;
        logic [3:0]  ctl;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] r, exp_r;
        logic        z, e, exp_z, exp_e;
        int          lat, exp_lat;
        logic [3:0]  ctl, pre_ctl, exp_c;
        logic [5:0]  fl[8];
        logic        saw_valid;

        vecs[0]  = '{"add",      3'b010, 6'd32, 32'd5,        32'd7,        32'd12,         1'b0, 1'b0, 1,  4'd2};
        vecs[1]  = '{"beq_sub",  3'b001, 6'd0,  32'd9,        32'd9,        32'd0,          1'b1, 1'b0, 1,  4'd6};
        vecs[2]  = '{"mult_a",   3'b010, 6'd24, 32'h00001234, 32'h00000100, 32'h00123400,   1'b0, 1'b0, 32, 4'd2};
        vecs[3]  = '{"mult_ff",  3'b010, 6'd24, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   1'b0, 1'b0, 32, 4'd2};
        vecs[4]  = '{"ill_fn3f", 3'b010, 6'h3F, 32'd1,        32'd2,        32'd0,          1'b0, 1'b1, 0,  4'd0};
        vecs[5]  = '{"ill_op7",  3'b111, 6'd32, 32'd1,        32'd2,        32'd0,          1'b0, 1'b1, 0,  4'd0};
        vecs[6]  = '{"or",       3'b100, 6'd0,  32'h000000F0, 32'h0000000F, 32'h000000FF,   1'b0, 1'b0, 1,  4'd1};
        vecs[7]  = '{"and",      3'b010, 6'd36, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0,   1'b0, 1'b0, 1,  4'd0};
        vecs[8]  = '{"slt",      3'b010, 6'd42, 32'hFFFFFFFF, 32'd1,        32'd1,          1'b0, 1'b0, 1,  4'd7};
        vecs[9]  = '{"nor",      3'b010, 6'd39, 32'd0,        32'd0,        32'hFFFFFFFF,   1'b0, 1'b0, 1,  4'd12};
        vecs[10] = '{"lui",      3'b101, 6'd0,  32'd0,        32'h00001234, 32'h12340000,   1'b0, 1'b0, 1,  4'd9};
        vecs[11] = '{"mult_0",   3'b010, 6'd24, 32'd0,        32'h12345678, 32'd0,          1'b1, 1'b0, 32, 4'd2};

        rst_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        v0_req_valid = 1'b0; v0_rsp_ready = 1'b0;
        aluop_i = 3'd0; funct_i = 6'd0; src1_i = 32'd0; src2_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_result", rsp_result_o, 32'd0);
        chk("rst_zero_err", {30'd0, rsp_zero_o, rsp_err_o}, 32'd0);
        chk("rst_alu_ports", alu_src1_o | alu_src2_o | 32'(alu_ctrl_o), 32'd0);
        rst_i = 1'b0;

        // Directed vector table
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b, r, z, e, lat, ctl, pre_ctl);
            chk({vecs[i].name, "_result"}, r, vecs[i].res);
            chk({vecs[i].name, "_zero"}, 32'(z), 32'(vecs[i].zero));
            chk({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].err));
            chk({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].err) chk({vecs[i].name, "_ctrl_unchanged"}, 32'(ctl), 32'(pre_ctl));
            else             chk({vecs[i].name, "_ctrl"}, 32'(ctl), 32'(vecs[i].ctl));
        end

        // Randomized requests against the reference model
        fl = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd3, 6'd24};
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  op;
            logic [5:0]  fn;
            logic [31:0] a, b;
            int          k;
            op = 3'($urandom_range(0, 7));
            k  = $urandom_range(0, 9);
            fn = (k < 8) ? fl[k] : 6'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            model(op, fn, a, b, exp_r, exp_z, exp_e, exp_lat, exp_c);
            send(op, fn, a, b, r, z, e, lat, ctl, pre_ctl);
            chk("rand_result", r, exp_r);
            chk("rand_flags", {29'd0, z, e, 1'b0}, {29'd0, exp_z, exp_e, 1'b0});
            chk("rand_latency", 32'(lat), 32'(exp_lat));
            chk("rand_ctrl", 32'(ctl), exp_e ? 32'(pre_ctl) : 32'(exp_c));
        end

        // Backpressure: hold rsp_ready_i low while a competing request is offered
        @(negedge clk);
        aluop_i = 3'b010; funct_i = 6'd32; src1_i = 32'd5; src2_i = 32'd7; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(posedge clk);
        #1 chk("bp_valid", 32'(rsp_valid_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            aluop_i = 3'b100; src1_i = 32'd1; src2_i = 32'd2; req_valid_i = 1'b1;
            @(posedge clk);
            #1;
            chk("bp_hold_valid", 32'(rsp_valid_o), 32'd1);
            chk("bp_hold_result", rsp_result_o, 32'd12);
            chk("bp_req_ready", 32'(req_ready_o), 32'd0);
        end
        @(negedge clk);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0; req_valid_i = 1'b0;
        chk("bp_release_idle", {30'd0, req_ready_o, rsp_valid_o}, 32'b10);
        send(3'b001, 6'd0, 32'd20, 32'd8, r, z, e, lat, ctl, pre_ctl);
        chk("bp_next_result", r, 32'd12);

        // MULT_EN=0: funct 24 is illegal
        @(negedge clk);
        aluop_i = 3'b010; funct_i = 6'd24; src1_i = 32'd3; src2_i = 32'd4; v0_req_valid = 1'b1;
        @(posedge clk);
        #1 v0_req_valid = 1'b0;
        chk("nomul_valid", 32'(v0_rsp_valid), 32'd1);
        chk("nomul_err", 32'(v0_rsp_err), 32'd1);
        chk("nomul_result", v0_rsp_result, 32'd0);
        @(negedge clk);
        v0_rsp_ready = 1'b1;
        @(posedge clk);
        #1 v0_rsp_ready = 1'b0;

        // Async reset in the middle of a MULT
        @(negedge clk);
        aluop_i = 3'b010; funct_i = 6'd24; src1_i = 32'd3; src2_i = 32'd5; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_i = 1'b1;
        #1;
        chk("mrst_rsp", {rsp_result_o[30:0], rsp_valid_o} | 32'({rsp_zero_o, rsp_err_o}), 32'd0);
        chk("mrst_alu", alu_src1_o | alu_src2_o | 32'(alu_ctrl_o), 32'd0);
        chk("mrst_req_ready", 32'(req_ready_o), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        saw_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1 if (rsp_valid_o) saw_valid = 1'b1;
        end
        chk("mrst_no_response", 32'(saw_valid), 32'd0);
        chk("mrst_ready_after", 32'(req_ready_o), 32'd1);
        send(3'b100, 6'd0, 32'h000000F0, 32'h0000000F, r, z, e, lat, ctl, pre_ctl);
        chk("mrst_or_result", r, 32'h000000FF);
        chk("mrst_or_err", 32'(e), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing side of the 32-bit ALU interface: accepts decoded-instruction requests, translates ALUOp/funct into the ALU's 4-bit control code and drives the ALU operand/control inputs.
- Captures result and zero flag, then returns them over a valid/ready response channel.
- Adds multi-cycle MULT (low 32 bits) by iterating the ALU ADD op 32 times.
- Sits between the decode/control path and the combinational ALU.

Parameters:
MUL_EN, 1, 1 = funct 24 (mult) supported; 0 = funct 24 is decoded as illegal.

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous reset, active-high
req_valid_i  input  1  request valid
req_ready_o  output  1  sequencer can accept a request
aluop_i  input  3  ALUOp from main control
funct_i  input  6  R-type funct field
src1_i  input  32  operand 1
src2_i  input  32  operand 2
alu_src1_o  output  32  to ALU src1
alu_src2_o  output  32  to ALU src2
alu_ctrl_o  output  4  to ALU ctrl
alu_result_i  input  32  from ALU result
alu_zero_i  input  1  from ALU zero
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  consumer accepts response
rsp_result_o  output  32  result
rsp_zero_o  output  1  result == 0
rsp_err_o  output  1  illegal ALUOp/funct

Behaviour:
- Reset (async, rst_i=1): state IDLE; all outputs 0 except req_ready_o=1 once in IDLE; in-flight request/response dropped, no partial response after release.
- Decode, ALUOp to ctrl: 000 to 2 (ADD); 001 to 6 (SUB); 011 to 7 (SLT); 100 to 1 (OR); 101 to 9 (LUI); 010 uses funct; 110/111 illegal.
- Decode, funct to ctrl (ALUOp 010): 32 to 2; 34 to 6; 36 to 0; 37 to 1; 39 to 12; 42 to 7; 3 to 8; 24 to MULT (when MUL_EN=1). Any other funct is illegal.
- States: IDLE, ISSUE, MUL, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - Accept on edge where req_valid_i & req_ready_o.
  - Operands and decoded ctrl are latched into internal registers.
  - Next state: legal single op to ISSUE; MULT to MUL (acc=0, m=src1, q=src2, cnt=0); illegal to RESP with result=0, zero=0, err=1.
- ISSUE (1 cycle):
  - alu_src1_o/alu_src2_o/alu_ctrl_o come from latched registers only; no combinational path from req_* inputs to ALU ports.
  - At edge, capture alu_result_i into rsp_result_o and alu_zero_i into rsp_zero_o; err=0; go to RESP.
- MUL (exactly 32 cycles, cnt 0..31, no early exit):
  - Drive alu_ctrl_o=2, alu_src1_o=acc, alu_src2_o = q[0] ? m : 0.
  - Each edge: acc=alu_result_i, m=m<<1, q=q>>1, cnt++.
  - After cnt=31 edge, go to RESP with result=acc, zero=(acc==0), err=0.
  - Result is modulo 2^32; overflow discarded.
- RESP:
  - rsp_valid_o=1; result/zero/err held stable until rsp_ready_i=1.
  - Edge with rsp_ready_i=1 returns to IDLE.
  - Request cannot be accepted in the same cycle (req_ready_o=0 in RESP).
- Latency (edges from accept edge to rsp_valid_o high): illegal 0, single op 1, MULT 32.
- Minimum request spacing: 3 cycles for single op, 34 for MULT.
- ALU outputs outside ISSUE/MUL hold their last driven values (0 after reset); the ALU result is ignored there.
- req_valid_i while not ready: ignored; requester must hold the request.
- rsp_ready_i outside RESP: ignored.

Test Plan:
- Add: aluop=010, funct=32, src1=5, src2=7 → alu_ctrl_o=2 during ISSUE, rsp_valid_o 1 edge after accept, result=12, zero=0, err=0.
- Beq sub: aluop=001, src1=src2=9 → alu_ctrl_o=6, result=0, zero=1.
- Mult:
  - 0x00001234 × 0x00000100 → result=0x00123400 with rsp_valid_o exactly 32 edges after accept.
  - 0xFFFFFFFF × 0xFFFFFFFF → result=0x00000001.
  - MUL_EN=0 with funct 24 → err=1.
- Illegal: aluop=010, funct=0x3F (and aluop=111) → rsp_valid_o right after accept edge, result=0, zero=0, err=1; ALU ctrl not changed.
- Backpressure: rsp_ready_i=0 for 5 cycles after valid → rsp_* stable, req_ready_o=0, new req_valid_i not accepted; release → IDLE next edge, next op correct.
- Reset mid-MUL (cnt=10): assert rst_i asynchronously → all outputs 0 immediately, no response emitted; after release req_ready_o=1, and a following OR 0xF0|0x0F returns 0xFF.
